// File: rtl/ntsc_write_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ntsc_write_if: frame-buffer write bus between capture writer and memory.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ntsc_write_if #(
    parameter int LOG_MEM    = 36,
    parameter int LOG_HCOUNT = 10,
    parameter int LOG_VCOUNT = 10
);
    logic                  ntsc_flag;
    logic [LOG_MEM-1:0]    ntsc_pixel;
    logic [LOG_HCOUNT-1:0] ntsc_x;
    logic [LOG_VCOUNT-1:0] ntsc_y;
    logic                  done_ntsc;

    modport master (
        output ntsc_flag,
        output ntsc_pixel,
        output ntsc_x,
        output ntsc_y,
        input  done_ntsc
    );

    modport slave (
        input  ntsc_flag,
        input  ntsc_pixel,
        input  ntsc_x,
        input  ntsc_y,
        output done_ntsc
    );
endinterface
`default_nettype wire

// File: rtl/ntsc_write.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ntsc_write: packs 6/6/6 camera pixels two per word and queues frame-buffer |
// | writes behind a small FIFO.                          Revision: 1.0         |
// +----------------------------------------------------------------------------+
module ntsc_write #(
    parameter int LOG_DEPTH  = 2,
    parameter int LOG_HCOUNT = 10,
    parameter int LOG_VCOUNT = 10,
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         pixel_valid,
    input  logic         sof,
    input  logic [7:0]   pixel_y,
    input  logic [7:0]   pixel_cb,
    input  logic [7:0]   pixel_cr,
    ntsc_write_if.master mem,
    output logic         frame_flag,
    output logic         overflow
);
    localparam int LOG_TRUNC = 18;
    localparam int LOG_MEM   = 2 * LOG_TRUNC;
    localparam int DEPTH     = 1 << LOG_DEPTH;
    localparam int ENTRY_W   = LOG_MEM + LOG_HCOUNT + LOG_VCOUNT;

    localparam logic [LOG_DEPTH:0]    FULL_COUNT  = (LOG_DEPTH + 1)'(DEPTH);
    localparam logic [LOG_HCOUNT-1:0] LAST_X      = LOG_HCOUNT'(H_PIXELS - 1);
    localparam logic [LOG_HCOUNT-1:0] LAST_WORD_X = LOG_HCOUNT'(H_PIXELS - 2);
    localparam logic [LOG_VCOUNT-1:0] LAST_Y      = LOG_VCOUNT'(V_LINES - 1);
    localparam logic [LOG_VCOUNT-1:0] END_Y       = LOG_VCOUNT'(V_LINES);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        REQUEST = 1'b1
    } state_t;

    state_t state, state_next;

    logic [LOG_HCOUNT-1:0] x_cnt, cur_x, tag_x;
    logic [LOG_VCOUNT-1:0] y_cnt, cur_y;
    logic [LOG_TRUNC-1:0]  trunc, half;
    logic                  accept, word_done, push, pop, drop;

    logic [ENTRY_W-1:0]    fifo [DEPTH];
    logic [ENTRY_W-1:0]    new_entry, head_next;
    logic [LOG_DEPTH-1:0]  wr_ptr, rd_ptr, rd_next;
    logic [LOG_DEPTH:0]    count, count_after_pop, count_next;

    logic [LOG_MEM-1:0]    head_word;
    logic [LOG_HCOUNT-1:0] head_x;
    logic [LOG_VCOUNT-1:0] head_y;

    logic                  unused_lsbs;
    assign unused_lsbs = ^{pixel_y[1:0], pixel_cb[1:0], pixel_cr[1:0]};

    // sof overrides the running counters so the marked pixel lands at (0,0)
    always_comb begin
        trunc     = {pixel_y[7:2], pixel_cb[7:2], pixel_cr[7:2]};
        cur_x     = sof ? '0 : x_cnt;
        cur_y     = sof ? '0 : y_cnt;
        tag_x     = {cur_x[LOG_HCOUNT-1:1], 1'b0};
        accept    = pixel_valid && (sof || (y_cnt < END_Y));
        word_done = accept && cur_x[0];
        new_entry = {half, trunc, tag_x, cur_y};
    end

    // A full FIFO can still take a word when the head leaves in the same cycle
    always_comb begin
        pop             = mem.done_ntsc && mem.ntsc_flag;
        push            = word_done && ((count != FULL_COUNT) || pop);
        drop            = word_done && !push;
        count_after_pop = count - (LOG_DEPTH + 1)'(pop);
        count_next      = count_after_pop + (LOG_DEPTH + 1)'(push);
        rd_next         = rd_ptr + LOG_DEPTH'(pop);
        if (count_after_pop != '0) begin
            head_next = fifo[rd_next];
        end else if (push) begin
            head_next = new_entry;
        end else begin
            head_next = {head_word, head_x, head_y};
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            half       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_word  <= '0;
            head_x     <= '0;
            head_y     <= '0;
            frame_flag <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                if (cur_x == LAST_X) begin
                    x_cnt <= '0;
                    y_cnt <= cur_y + LOG_VCOUNT'(1);
                end else begin
                    x_cnt <= cur_x + LOG_HCOUNT'(1);
                    y_cnt <= cur_y;
                end
            end
            if (accept && !cur_x[0]) begin
                half <= trunc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            end
            rd_ptr                     <= rd_next;
            count                      <= count_next;
            {head_word, head_x, head_y} <= head_next;
            frame_flag <= pop && (head_x == LAST_WORD_X) && (head_y == LAST_Y);
            if (accept && sof) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count_next != '0) state_next = REQUEST;
            REQUEST: if (count_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign mem.ntsc_flag  = (state == REQUEST);
    assign mem.ntsc_pixel = head_word;
    assign mem.ntsc_x     = head_x;
    assign mem.ntsc_y     = head_y;

endmodule
`default_nettype wire

// File: tb/tb_ntsc_write.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ntsc_write: directed self-checking bench for ntsc_write.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ntsc_write;
    localparam int V_LINES = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       pixel_valid;
    logic       sof;
    logic [7:0] pixel_y, pixel_cb, pixel_cr;
    logic       frame_flag;
    logic       overflow;

    ntsc_write_if bus ();

    ntsc_write #(
        .LOG_DEPTH (2),
        .LOG_HCOUNT(10),
        .LOG_VCOUNT(10),
        .H_PIXELS  (640),
        .V_LINES   (V_LINES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pixel_valid(pixel_valid),
        .sof        (sof),
        .pixel_y    (pixel_y),
        .pixel_cb   (pixel_cb),
        .pixel_cr   (pixel_cr),
        .mem        (bus),
        .frame_flag (frame_flag),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int       n_checks = 0;
    int       n_fail   = 0;
    bit       auto_done = 1'b0;
    bit       mon_en    = 1'b0;
    int       pop_cnt, tag_err, ff_cnt, ff_bad;
    int       exp_x, exp_y;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word the DUT must build from the even pixel at x and the odd pixel at x+1
    function automatic logic [35:0] exp_word(input int x);
        logic [5:0] b;
        b = 6'(x);
        return {b, b + 6'd1, b + 6'd2, b + 6'd1, b + 6'd2, b + 6'd3};
    endfunction

    // One clock: apply inputs now, return at the following falling edge
    task automatic drive_raw(input bit pv, input bit s, input logic [7:0] y, input logic [7:0] cb,
                             input logic [7:0] cr, input bit d);
        bit pop;
        bit popped_end;
        pixel_valid   = pv;
        sof           = s;
        pixel_y       = y;
        pixel_cb      = cb;
        pixel_cr      = cr;
        bus.done_ntsc = auto_done ? bus.ntsc_flag : d;
        pop           = bus.done_ntsc && bus.ntsc_flag && !reset;
        popped_end    = pop && (bus.ntsc_x == 10'd638) && (bus.ntsc_y == 10'(V_LINES - 1));
        if (pop && mon_en) begin
            if (bus.ntsc_x !== 10'(exp_x) || bus.ntsc_y !== 10'(exp_y) ||
                bus.ntsc_pixel !== exp_word(exp_x))
                tag_err++;
            pop_cnt++;
            if (exp_x == 638) begin
                exp_x = 0;
                exp_y++;
            end else begin
                exp_x += 2;
            end
        end
        @(negedge clock);
        if (frame_flag) begin
            ff_cnt++;
            if (!popped_end) ff_bad++;
        end
    endtask

    task automatic drive(input bit pv, input bit s, input int x, input bit d);
        drive_raw(pv, s, 8'(x * 4), 8'(x * 4 + 4), 8'(x * 4 + 8), d);
    endtask

    initial begin
        reset       = 1'b1;
        pixel_valid = 1'b0;
        sof         = 1'b0;
        pixel_y     = '0;
        pixel_cb    = '0;
        pixel_cr    = '0;
        bus.done_ntsc = 1'b0;
        ff_cnt = 0; ff_bad = 0; pop_cnt = 0; tag_err = 0;
        exp_x = 0; exp_y = 0;

        // Reset state
        repeat (3) drive(0, 0, 0, 0);
        check("rst_flag", 64'(bus.ntsc_flag), 64'd0);
        check("rst_pixel", 64'(bus.ntsc_pixel), 64'd0);
        check("rst_x", 64'(bus.ntsc_x), 64'd0);
        check("rst_y", 64'(bus.ntsc_y), 64'd0);
        check("rst_frame_flag", 64'(frame_flag), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;

        // Single word
        drive_raw(1, 1, 8'hFC, 8'h80, 8'h04, 0);
        check("single_flag_early", 64'(bus.ntsc_flag), 64'd0);
        drive_raw(1, 0, 8'h04, 8'h08, 8'h0C, 0);
        check("single_flag", 64'(bus.ntsc_flag), 64'd1);
        check("single_pixel", 64'(bus.ntsc_pixel),
              64'({6'h3F, 6'h20, 6'h01, 6'h01, 6'h02, 6'h03}));
        check("single_x", 64'(bus.ntsc_x), 64'd0);
        check("single_y", 64'(bus.ntsc_y), 64'd0);
        drive(0, 0, 0, 0);
        check("single_hold_pixel", 64'(bus.ntsc_pixel),
              64'({6'h3F, 6'h20, 6'h01, 6'h01, 6'h02, 6'h03}));
        drive(0, 0, 0, 1);
        check("single_flag_after_pop", 64'(bus.ntsc_flag), 64'd0);

        // Full frame (640 x V_LINES) with immediate write responses
        ff_cnt = 0; ff_bad = 0; pop_cnt = 0; tag_err = 0; exp_x = 0; exp_y = 0;
        auto_done = 1'b1;
        mon_en    = 1'b1;
        for (int y = 0; y < V_LINES; y++)
            for (int x = 0; x < 640; x++)
                drive(1, (x == 0 && y == 0), x, 0);
        repeat (4) drive(0, 0, 0, 0);
        check("frame_writes", 64'(pop_cnt), 64'(320 * V_LINES));
        check("frame_tag_errors", 64'(tag_err), 64'd0);
        check("frame_flag_pulses", 64'(ff_cnt), 64'd1);
        check("frame_flag_misplaced", 64'(ff_bad), 64'd0);
        check("frame_overflow", 64'(overflow), 64'd0);
        // Past the last line, pixels are ignored until the next sof
        for (int k = 0; k < 4; k++) drive(1, 0, k, 0);
        check("past_end_writes", 64'(pop_cnt), 64'(320 * V_LINES));
        check("past_end_flag", 64'(bus.ntsc_flag), 64'd0);
        auto_done = 1'b0;
        mon_en    = 1'b0;

        // Overflow: 10 pixels, no write service, depth 4
        ff_cnt = 0;
        for (int p = 0; p < 10; p++) drive(1, p == 0, p, 0);
        check("ovf_overflow", 64'(overflow), 64'd1);
        check("ovf_flag", 64'(bus.ntsc_flag), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf_x%0d", k), 64'(bus.ntsc_x), 64'(2 * k));
            check($sformatf("ovf_pixel%0d", k), 64'(bus.ntsc_pixel), 64'(exp_word(2 * k)));
            drive(0, 0, 0, 1);
        end
        check("ovf_no_x8", 64'(bus.ntsc_flag), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Simultaneous push and pop on a full FIFO
        for (int p = 0; p < 9; p++) drive(1, p == 0, p, 0);
        check("sim_overflow_cleared", 64'(overflow), 64'd0);
        drive(1, 0, 9, 1);
        check("sim_overflow", 64'(overflow), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sim_x%0d", k), 64'(bus.ntsc_x), 64'(2 * k + 2));
            check($sformatf("sim_pixel%0d", k), 64'(bus.ntsc_pixel), 64'(exp_word(2 * k + 2)));
            drive(0, 0, 0, 1);
        end
        check("sim_drained", 64'(bus.ntsc_flag), 64'd0);

        // Mid-line sof at x=101 after an overflow
        for (int p = 0; p < 10; p++) drive(1, p == 0, p, 0);
        auto_done = 1'b1;
        for (int p = 10; p <= 100; p++) drive(1, 0, p, 0);
        auto_done = 1'b0;
        check("mid_overflow_before", 64'(overflow), 64'd1);
        drive_raw(1, 1, 8'h40, 8'h44, 8'h48, 0);
        drive_raw(1, 0, 8'h50, 8'h54, 8'h58, 0);
        check("mid_flag", 64'(bus.ntsc_flag), 64'd1);
        check("mid_x", 64'(bus.ntsc_x), 64'd0);
        check("mid_y", 64'(bus.ntsc_y), 64'd0);
        check("mid_pixel", 64'(bus.ntsc_pixel),
              64'({6'h10, 6'h11, 6'h12, 6'h14, 6'h15, 6'h16}));
        check("mid_overflow", 64'(overflow), 64'd0);
        drive(0, 0, 0, 1);
        check("mid_no_frame_flag", 64'(ff_cnt), 64'd0);

        // Reset with three words queued (x=2,4,6)
        for (int p = 0; p < 8; p++) drive(1, p == 0, p, p == 2);
        check("rmr_flag", 64'(bus.ntsc_flag), 64'd1);
        check("rmr_head_x", 64'(bus.ntsc_x), 64'd2);
        reset = 1'b1;
        drive(0, 0, 0, 0);
        reset = 1'b0;
        check("rmr_flag_after", 64'(bus.ntsc_flag), 64'd0);
        check("rmr_pixel_after", 64'(bus.ntsc_pixel), 64'd0);
        check("rmr_x_after", 64'(bus.ntsc_x), 64'd0);
        check("rmr_y_after", 64'(bus.ntsc_y), 64'd0);
        check("rmr_overflow_after", 64'(overflow), 64'd0);
        check("rmr_frame_flag_after", 64'(frame_flag), 64'd0);
        drive(0, 0, 0, 1);
        check("rmr_stray_done_flag", 64'(bus.ntsc_flag), 64'd0);
        check("rmr_stray_done_x", 64'(bus.ntsc_x), 64'd0);
        drive(1, 0, 20, 0);
        drive(1, 0, 21, 0);
        check("rmr_restart_flag", 64'(bus.ntsc_flag), 64'd1);
        check("rmr_restart_x", 64'(bus.ntsc_x), 64'd0);
        check("rmr_restart_pixel", 64'(bus.ntsc_pixel), 64'(exp_word(20)));
        drive(0, 0, 0, 1);
        check("rmr_final_flag", 64'(bus.ntsc_flag), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
